// File: rtl/bullet.sv
// Bullet for one tank: spawns at the owning tank's centre, moves one pixel
// every MOVE_TIME+1 clocks, dies on the screen edge or a wall cell, and on
// striking the opposing tank pulses hit and blocks re-fire for a cooldown.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         asynchronous active-low reset
//   game_over     forces the bullet back to idle; suppresses hit
//   fire          fire request from the owning tank (accepted only in idle)
//   fire_dir      tank direction at fire time (00 up, 01 down, 10 left, 11 right)
//   tank_x/y      owning tank top-left
//   enemy_x/y     opposing tank top-left (32x32 box)
//   enemy_active  opposing tank alive
//   wall_map      bit r*16+c set = wall at row r = x/32, column c = y/32
//   hit           one-clock pulse on striking the opposing tank
//   busy          high whenever not idle
//   bullet_state  {1, PLAYER_INDEX[1:0], active, bx, by, dir, 6'b0}
module bullet #(
    parameter int unsigned PLAYER_INDEX  = 0,
    parameter int unsigned MOVE_TIME     = 200000,
    parameter int unsigned COOLDOWN_TIME = 4000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         game_over,
    input  logic         fire,
    input  logic [1:0]   fire_dir,
    input  logic [9:0]   tank_x,
    input  logic [9:0]   tank_y,
    input  logic [9:0]   enemy_x,
    input  logic [9:0]   enemy_y,
    input  logic         enemy_active,
    input  logic [255:0] wall_map,
    output logic         hit,
    output logic         busy,
    output logic [31:0]  bullet_state
);

    localparam int unsigned MaxTime = (MOVE_TIME > COOLDOWN_TIME) ? MOVE_TIME : COOLDOWN_TIME;
    localparam int unsigned TimerW  = (MaxTime < 1) ? 1 : $clog2(MaxTime + 1);
    localparam logic [TimerW-1:0] MoveLoad = TimerW'(MOVE_TIME);
    localparam logic [TimerW-1:0] CoolLoad = TimerW'(COOLDOWN_TIME);
    localparam logic [1:0]        PlayerId = 2'(PLAYER_INDEX);

    typedef enum logic [1:0] {StIdle, StFly, StCooldown} state_e;

    state_e             state_q, state_d;
    logic [9:0]         bx_q, bx_d, by_q, by_d;
    logic [1:0]         dir_q, dir_d;
    logic [TimerW-1:0]  timer_q, timer_d;

    // Single timer serves both the step interval in flight and the cooldown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            bx_q    <= '0;
            by_q    <= '0;
            dir_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    // Box overlap at 11 bits so enemy_x+32 cannot wrap near the 10-bit limit.
    logic [10:0] bx_w, by_w, ex_w, ey_w;
    logic        overlap;

    assign bx_w = {1'b0, bx_q};
    assign by_w = {1'b0, by_q};
    assign ex_w = {1'b0, enemy_x};
    assign ey_w = {1'b0, enemy_y};

    assign overlap = (bx_w < ex_w + 11'd32) && (bx_w + 11'd8 > ex_w) &&
                     (by_w < ey_w + 11'd32) && (by_w + 11'd8 > ey_w);

    // Step evaluation: next position and the two corners on its leading edge.
    logic [10:0] nbx, nby, ax, ay, cx, cy, lead;
    logic        underflow, overflow, range_bad, wall_hit, blocked;

    always_comb begin
        nbx       = bx_w;
        nby       = by_w;
        underflow = 1'b0;
        unique case (dir_q)
            2'b00: begin
                nby       = by_w - 11'd1;
                underflow = (by_q == 10'd0);
            end
            2'b01: nby = by_w + 11'd1;
            2'b10: begin
                nbx       = bx_w - 11'd1;
                underflow = (bx_q == 10'd0);
            end
            2'b11: nbx = bx_w + 11'd1;
        endcase

        ax = nbx;
        ay = nby;
        cx = nbx;
        cy = nby;
        unique case (dir_q)
            2'b00: cx = nbx + 11'd7;
            2'b01: begin
                ay = nby + 11'd7;
                cx = nbx + 11'd7;
                cy = nby + 11'd7;
            end
            2'b10: cy = nby + 11'd7;
            2'b11: begin
                ax = nbx + 11'd7;
                cx = nbx + 11'd7;
                cy = nby + 11'd7;
            end
        endcase

        lead      = dir_q[1] ? ax : ay;
        overflow  = dir_q[0] && (lead > 11'd511);
        range_bad = (|ax[10:9]) || (|ay[10:9]) || (|cx[10:9]) || (|cy[10:9]);
        wall_hit  = wall_map[{ax[8:5], ay[8:5]}] || wall_map[{cx[8:5], cy[8:5]}];
        blocked   = underflow || overflow || range_bad || wall_hit;
    end

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        hit     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fire && !game_over) begin
                    bx_d    = tank_x + 10'd12;
                    by_d    = tank_y + 10'd12;
                    dir_d   = fire_dir;
                    timer_d = MoveLoad;
                    state_d = StFly;
                end
            end
            StFly: begin
                if (game_over) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (enemy_active && overlap) begin
                    hit     = 1'b1;
                    timer_d = CoolLoad;
                    state_d = StCooldown;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TimerW'(1);
                end else if (blocked) begin
                    state_d = StIdle;
                end else begin
                    bx_d    = nbx[9:0];
                    by_d    = nby[9:0];
                    timer_d = MoveLoad;
                end
            end
            StCooldown: begin
                if (game_over || timer_q == '0) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    assign busy         = (state_q != StIdle);
    assign bullet_state = {1'b1, PlayerId, (state_q == StFly), bx_q, by_q, dir_q, 6'b0};

endmodule
